// File: rtl/dffrsnq_bank_init_seq_if.sv
// Bus between configuration logic (master) and the dffrsnq bank load sequencer (slave).
// REQ/PAT/MASK : load request with target pattern and per-bit load mask
// Q_I          : bank readback used by the optional verify step
// BUSY/ACK     : sequencer status and one-cycle completion pulse
// CLK_EN       : bank clock enable
// RN_O/SETN_O  : per-bit active-low async reset/set to the bank
// ERR          : sticky verify mismatch flag
interface dffrsnq_bank_init_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             REQ;
  logic [WIDTH-1:0] PAT;
  logic [WIDTH-1:0] MASK;
  logic [WIDTH-1:0] Q_I;
  logic             BUSY;
  logic             ACK;
  logic             CLK_EN;
  logic [WIDTH-1:0] RN_O;
  logic [WIDTH-1:0] SETN_O;
  logic             ERR;

  modport master (
    output REQ, PAT, MASK, Q_I,
    input  BUSY, ACK, CLK_EN, RN_O, SETN_O, ERR
  );

  modport slave (
    input  REQ, PAT, MASK, Q_I,
    output BUSY, ACK, CLK_EN, RN_O, SETN_O, ERR
  );
endinterface

// File: rtl/dffrsnq_bank_init_seq.sv
// Loads a bank of async set/reset flops with a pattern by pulsing per-bit RN/SETN,
// holding each pulse PULSE_CYC cycles and keeping the bank clock off for REC_CYC
// cycles after release. RN and SETN are never low together on one bit.
// Ports:
//   CLK : sequencer clock
//   RST : asynchronous reset, active-high (clears the bank, then runs recovery)
//   bus : slave side of dffrsnq_bank_init_seq_if (REQ/PAT/MASK/Q_I in,
//         BUSY/ACK/CLK_EN/RN_O/SETN_O/ERR out); all outputs registered
// Optional feature: define DFFRSNQ_BANK_INIT_SEQ_VERIFY_EN to compare the masked
// readback Q_I against the captured pattern at completion and raise sticky ERR.
module dffrsnq_bank_init_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned REC_CYC   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  dffrsnq_bank_init_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(REC_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PULSE, RECOV, DONE} state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             boot, boot_d;   // recovery started by reset: ends in IDLE without ACK
  logic             hold, hold_d;   // first edge after reset only releases RN
  logic [WIDTH-1:0] pat_cap, pat_d;
  logic [WIDTH-1:0] mask_cap, mask_d;

  logic [WIDTH-1:0] rn_q, rn_d;
  logic [WIDTH-1:0] setn_q, setn_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;
  logic             clk_en_q, clk_en_d;
  logic             err_q, err_d;

  logic             cnt_last;
  logic             mismatch;

  // Down-count stops at 1 so the counter can never wrap.
  assign cnt_last = (cnt <= CNT_ONE);

`ifdef DFFRSNQ_BANK_INIT_SEQ_VERIFY_EN
  assign mismatch = (((bus.Q_I ^ pat_cap) & mask_cap) != '0);
`else
  assign mismatch = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= RECOV;
      cnt      <= REC_LD;
      boot     <= 1'b1;
      hold     <= 1'b1;
      pat_cap  <= '0;
      mask_cap <= '0;
      rn_q     <= '0;
      setn_q   <= '1;
      busy_q   <= 1'b1;
      ack_q    <= 1'b0;
      clk_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      boot     <= boot_d;
      hold     <= hold_d;
      pat_cap  <= pat_d;
      mask_cap <= mask_d;
      rn_q     <= rn_d;
      setn_q   <= setn_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      clk_en_q <= clk_en_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counter and capture logic.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    boot_d  = boot;
    hold_d  = 1'b0;
    pat_d   = pat_cap;
    mask_d  = mask_cap;
    unique case (state)
      IDLE: begin
        if (bus.REQ) begin
          pat_d  = bus.PAT;
          mask_d = bus.MASK;
          // An empty mask completes in place: nothing to pulse.
          if (bus.MASK != '0) begin
            state_d = PULSE;
            cnt_d   = PULSE_LD;
          end
        end
      end
      PULSE: begin
        if (cnt_last) begin
          state_d = RECOV;
          cnt_d   = REC_LD;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      RECOV: begin
        if (!hold) begin
          if (cnt_last) begin
            state_d = boot ? IDLE : DONE;
            boot_d  = 1'b0;
          end else begin
            cnt_d = cnt - CNT_ONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    rn_d     = '1;
    setn_d   = '1;
    busy_d   = (state_d != IDLE);
    clk_en_d = (state_d == IDLE);
    ack_d    = (state == DONE) || (state == IDLE && bus.REQ && bus.MASK == '0);
    err_d    = err_q;
    // Masked bits get exactly one of RN/SETN low; unmasked bits stay 1/1.
    if (state_d == PULSE) begin
      rn_d   = ~mask_d | pat_d;
      setn_d = ~mask_d | ~pat_d;
    end
    if (state == IDLE && bus.REQ) begin
      err_d = 1'b0;
    end else if (state == DONE && mismatch) begin
      err_d = 1'b1;
    end
  end

  assign bus.RN_O   = rn_q;
  assign bus.SETN_O = setn_q;
  assign bus.BUSY   = busy_q;
  assign bus.ACK    = ack_q;
  assign bus.CLK_EN = clk_en_q;
  assign bus.ERR    = err_q;

endmodule
